// File: rtl/video_mnist_seg_param_ctl_pkg.sv
// Shared definitions for the MNIST segmentation parameter controller:
// register word offsets, core ID, FSM state encoding and a byte-lane merge helper.
package video_mnist_seg_param_ctl_pkg;

    localparam logic [31:0] CORE_ID_VALUE = 32'h527A_0110;

    // Word offsets; byte address = word << 2. Active readbacks sit 0x20 above their shadows.
    localparam int unsigned ADR_CORE_ID     = 0;
    localparam int unsigned ADR_CONTROL     = 1;
    localparam int unsigned ADR_STATUS      = 2;
    localparam int unsigned ADR_FRAME_COUNT = 3;
    localparam int unsigned ADR_TH          = 4;
    localparam int unsigned ADR_INV         = 5;
    localparam int unsigned ADR_MODE        = 6;
    localparam int unsigned ADR_ENABLE      = 7;
    localparam int unsigned ADR_ACT_TH      = 12;
    localparam int unsigned ADR_ACT_INV     = 13;
    localparam int unsigned ADR_ACT_MODE    = 14;
    localparam int unsigned ADR_ACT_ENABLE  = 15;
    localparam int unsigned ADR_IRQ_ENABLE  = 16;
    localparam int unsigned ADR_IRQ_STATUS  = 17;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    function automatic logic [31:0] applySel(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [3:0]  sel);
        logic [31:0] merged;
        merged = oldVal;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) merged[8*b +: 8] = newVal[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/video_mnist_seg_param_ctl_if.sv
// Zero-wait Wishbone slave bus used by the parameter controller.
interface video_mnist_seg_param_ctl_if #(
    parameter int unsigned ADR_W = 8
);
    logic [ADR_W-1:0] s_wb_adr_i;
    logic [31:0]      s_wb_dat_i;
    logic [31:0]      s_wb_dat_o;
    logic             s_wb_we_i;
    logic [3:0]       s_wb_sel_i;
    logic             s_wb_stb_i;
    logic             s_wb_ack_o;

    modport master (
        output s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i,
        input  s_wb_dat_o, s_wb_ack_o
    );

    modport slave (
        input  s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i,
        output s_wb_dat_o, s_wb_ack_o
    );
endinterface

// File: rtl/video_mnist_seg_param_ctl.sv
// Wishbone-programmable shadow parameters committed to the video path only at frame start.
// Optional frame/commit interrupt enabled by `define VIDEO_MNIST_SEG_PARAM_CTL_IRQ_EN.
module video_mnist_seg_param_ctl
    import video_mnist_seg_param_ctl_pkg::*;
#(
    parameter int unsigned            WB_ADR_WIDTH    = 8,
    parameter int unsigned            WB_DAT_WIDTH    = 32,
    parameter int unsigned            WB_SEL_WIDTH    = 4,
    parameter int unsigned            DATA_WIDTH      = 8,
    parameter logic [DATA_WIDTH-1:0]  INIT_PARAM_TH   = DATA_WIDTH'(127),
    parameter logic                   INIT_PARAM_INV  = 1'b0,
    parameter logic [2:0]             INIT_PARAM_MODE = 3'b111,
    parameter logic                   INIT_ENABLE     = 1'b1
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    video_mnist_seg_param_ctl_if.slave wb,
    input  logic                      mon_tuser,
    input  logic                      mon_tvalid,
    input  logic                      mon_tready,
    output logic                      param_enable,
    output logic [DATA_WIDTH-1:0]     param_th,
    output logic                      param_inv,
    output logic [2:0]                param_mode,
    output logic                      param_update,
    output logic                      irq
);

    logic                    frameStart, wrEn, wrCtrl, updateReq, forceReq, commitNow, pending;
    logic [31:0]             adrWord, thMerged;
    logic [WB_SEL_WIDTH-1:0] wbSel;
    logic [WB_DAT_WIDTH-1:0] rdata;
    logic                    unusedBits;
    state_e                  state_q;

    logic [DATA_WIDTH-1:0]   shadowTh_q, shadowTh_d, actTh_q;
    logic                    shadowInv_q, shadowInv_d, actInv_q;
    logic [2:0]              shadowMode_q, shadowMode_d, actMode_q;
    logic                    shadowEnable_q, shadowEnable_d, actEnable_q;
    logic [31:0]             frameCount_q, frameCount_d;
    logic                    frameSeen_q, update_q;

    assign frameStart = mon_tvalid & mon_tready & mon_tuser;
    assign adrWord    = 32'(wb.s_wb_adr_i);
    assign wbSel      = wb.s_wb_sel_i;
    assign wrEn       = wb.s_wb_stb_i & wb.s_wb_we_i;
    assign wrCtrl     = wrEn && (adrWord == ADR_CONTROL) && wbSel[0];
    assign updateReq  = wrCtrl & wb.s_wb_dat_i[0];
    assign forceReq   = wrCtrl & wb.s_wb_dat_i[1];
    assign pending    = (state_q == ST_PEND);
    assign commitNow  = forceReq | (pending & frameStart);
    assign thMerged   = applySel(32'(shadowTh_q), wb.s_wb_dat_i, wbSel);
    assign unusedBits = ^thMerged[31:DATA_WIDTH];

    always_comb begin
        shadowTh_d     = shadowTh_q;
        shadowInv_d    = shadowInv_q;
        shadowMode_d   = shadowMode_q;
        shadowEnable_d = shadowEnable_q;
        if (wrEn) begin
            case (adrWord)
                ADR_TH:     shadowTh_d = thMerged[DATA_WIDTH-1:0];
                ADR_INV:    if (wbSel[0]) shadowInv_d = wb.s_wb_dat_i[0];
                ADR_MODE:   if (wbSel[0]) shadowMode_d = wb.s_wb_dat_i[2:0];
                ADR_ENABLE: if (wbSel[0]) shadowEnable_d = wb.s_wb_dat_i[0];
                default:    ;
            endcase
        end
        frameCount_d = frameCount_q + 32'(frameStart);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            shadowTh_q     <= INIT_PARAM_TH;
            shadowInv_q    <= INIT_PARAM_INV;
            shadowMode_q   <= INIT_PARAM_MODE;
            shadowEnable_q <= INIT_ENABLE;
            frameCount_q   <= '0;
            frameSeen_q    <= 1'b0;
        end else begin
            shadowTh_q     <= shadowTh_d;
            shadowInv_q    <= shadowInv_d;
            shadowMode_q   <= shadowMode_d;
            shadowEnable_q <= shadowEnable_d;
            frameCount_q   <= frameCount_d;
            frameSeen_q    <= frameSeen_q | frameStart;
        end
    end

    // Actives load on the same edge the FSM enters COMMIT, so the fs beat itself still sees old values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            actTh_q     <= INIT_PARAM_TH;
            actInv_q    <= INIT_PARAM_INV;
            actMode_q   <= INIT_PARAM_MODE;
            actEnable_q <= INIT_ENABLE;
            update_q    <= 1'b0;
        end else begin
            update_q <= 1'b0;
            if (commitNow) begin
                state_q     <= ST_COMMIT;
                actTh_q     <= shadowTh_q;
                actInv_q    <= shadowInv_q;
                actMode_q   <= shadowMode_q;
                actEnable_q <= shadowEnable_q;
                update_q    <= 1'b1;
            end else begin
                unique case (state_q)
                    ST_IDLE:   if (updateReq) state_q <= ST_PEND;
                    ST_PEND:   ;
                    ST_COMMIT: state_q <= updateReq ? ST_PEND : ST_IDLE;
                    default:   state_q <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef VIDEO_MNIST_SEG_PARAM_CTL_IRQ_EN
    logic [1:0] irqEnable_q, irqEnable_d, irqStatus_q, irqStatus_d;
    logic       irq_q;

    // Event sets are OR-ed after the W1C so a same-cycle clear never loses an event.
    always_comb begin
        irqEnable_d = irqEnable_q;
        irqStatus_d = irqStatus_q;
        if (wrEn && (adrWord == ADR_IRQ_ENABLE) && wbSel[0]) irqEnable_d = wb.s_wb_dat_i[1:0];
        if (wrEn && (adrWord == ADR_IRQ_STATUS) && wbSel[0]) irqStatus_d = irqStatus_q & ~wb.s_wb_dat_i[1:0];
        irqStatus_d = irqStatus_d | {commitNow, frameStart};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            irqEnable_q <= '0;
            irqStatus_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            irqEnable_q <= irqEnable_d;
            irqStatus_q <= irqStatus_d;
            irq_q       <= |(irqStatus_d & irqEnable_d);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (adrWord)
            ADR_CORE_ID:     rdata = CORE_ID_VALUE;
            ADR_CONTROL:     rdata = {31'd0, pending};
            ADR_STATUS:      rdata = {30'd0, frameSeen_q, pending};
            ADR_FRAME_COUNT: rdata = frameCount_q;
            ADR_TH:          rdata = 32'(shadowTh_q);
            ADR_INV:         rdata = {31'd0, shadowInv_q};
            ADR_MODE:        rdata = {29'd0, shadowMode_q};
            ADR_ENABLE:      rdata = {31'd0, shadowEnable_q};
            ADR_ACT_TH:      rdata = 32'(actTh_q);
            ADR_ACT_INV:     rdata = {31'd0, actInv_q};
            ADR_ACT_MODE:    rdata = {29'd0, actMode_q};
            ADR_ACT_ENABLE:  rdata = {31'd0, actEnable_q};
`ifdef VIDEO_MNIST_SEG_PARAM_CTL_IRQ_EN
            ADR_IRQ_ENABLE:  rdata = {30'd0, irqEnable_q};
            ADR_IRQ_STATUS:  rdata = {30'd0, irqStatus_q};
`endif
            default:         rdata = '0;
        endcase
    end

    assign wb.s_wb_dat_o = rdata;
    assign wb.s_wb_ack_o = wb.s_wb_stb_i;

    assign param_th     = actTh_q;
    assign param_inv    = actInv_q;
    assign param_mode   = actMode_q;
    assign param_enable = actEnable_q;
    assign param_update = update_q;

endmodule
